// File: rtl/mpmc10_app_cmd_gen.sv
// Command stage behind the mpmc10 write-back controller: turns controller state into MIG app_*
// strobes, walks per-strip read addresses and assembles returned 128-bit strips into a line.
`timescale 1ns/1ps
module mpmc10_app_cmd_gen #(
  parameter int         ADDR_WIDTH     = 29,
  parameter int         MAX_STRIPS     = 4,
  parameter logic [3:0] ST_IDLE        = 4'd0,
  parameter logic [3:0] ST_PRESET1     = 4'd1,
  parameter logic [3:0] ST_PRESET2     = 4'd2,
  parameter logic [3:0] ST_PRESET3     = 4'd3,
  parameter logic [3:0] ST_WRITE_DATA0 = 4'd4,
  parameter logic [3:0] ST_WRITE_DATA2 = 4'd6,
  parameter logic [3:0] ST_READ_DATA1  = 4'd9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              state,
  input  logic [31:0]             adr_i,
  input  logic [127:0]            dat_i,
  input  logic [15:0]             sel_i,
  input  logic [5:0]              num_strips,
  input  logic                    app_rdy,
  input  logic                    app_wdf_rdy,
  output logic                    app_en,
  output logic [2:0]              app_cmd,
  output logic [ADDR_WIDTH-1:0]   app_addr,
  output logic                    app_wdf_wren,
  output logic                    app_wdf_end,
  output logic [127:0]            app_wdf_data,
  output logic [15:0]             app_wdf_mask,
  input  logic [127:0]            app_rd_data,
  input  logic                    app_rd_data_valid,
  output logic [5:0]              req_strip_cnt,
  output logic [5:0]              resp_strip_cnt,
  output logic                    rd_data_valid,
  output logic [128*MAX_STRIPS-1:0] rd_line,
  output logic                    rd_line_valid
);

  localparam int IDX_W = (MAX_STRIPS > 1) ? $clog2(MAX_STRIPS) : 1;

  logic [ADDR_WIDTH-1:0]     r_base;
  logic [127:0]              r_wdf_data;
  logic [15:0]               r_wdf_mask;
  logic [5:0]                r_req_cnt;
  logic [5:0]                r_resp_cnt;
  logic [128*MAX_STRIPS-1:0] r_rd_line;
  logic                      r_line_done;
  logic                      r_line_valid;

  logic                  w_resp_state;
  logic                  w_beat_take;
  logic                  w_last_beat;
  logic                  w_req_take;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic [31:0]           w_idx_full;
  logic [IDX_W-1:0]      w_strip_idx;
  logic                  w_unused;

  // The write-data handshake is paced by the controller, so app_wdf_rdy is not needed here.
  assign w_unused = ^{app_wdf_rdy, adr_i[31:ADDR_WIDTH], adr_i[3:0]};

  assign w_resp_state = !((state == ST_IDLE) || (state == ST_PRESET1) ||
                          (state == ST_PRESET2) || (state == ST_PRESET3));
  assign w_beat_take  = w_resp_state && app_rd_data_valid && !r_line_done;
  assign w_last_beat  = !(r_resp_cnt < num_strips);
  assign w_req_take   = (state == ST_READ_DATA1) && app_rdy && (r_req_cnt < num_strips);
  assign w_rd_addr    = r_base + ADDR_WIDTH'({r_req_cnt, 4'h0});
  assign w_idx_full   = {26'd0, r_resp_cnt} % MAX_STRIPS;
  assign w_strip_idx  = w_idx_full[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_base       <= '0;
      r_wdf_data   <= '0;
      r_wdf_mask   <= '1;
      r_req_cnt    <= '0;
      r_resp_cnt   <= '0;
      r_rd_line    <= '0;
      r_line_done  <= 1'b0;
      r_line_valid <= 1'b0;
    end else begin
      r_line_valid <= 1'b0;
      if (state == ST_PRESET2) begin
        r_base      <= {adr_i[ADDR_WIDTH-1:4], 4'h0};
        r_wdf_data  <= dat_i;
        r_wdf_mask  <= ~sel_i;
        r_req_cnt   <= '0;
        r_resp_cnt  <= '0;
        r_line_done <= 1'b0;
      end
      if (w_req_take) begin
        r_req_cnt <= r_req_cnt + 6'd1;
      end
      // Once the last strip has landed, further beats are dropped until the next PRESET2.
      if (w_beat_take) begin
        r_rd_line[{w_strip_idx, 7'd0} +: 128] <= app_rd_data;
        if (w_last_beat) begin
          r_line_done  <= 1'b1;
          r_line_valid <= 1'b1;
        end else begin
          r_resp_cnt <= r_resp_cnt + 6'd1;
        end
      end
    end
  end

  always_comb begin
    app_en       = 1'b0;
    app_cmd      = 3'b001;
    app_addr     = w_rd_addr;
    app_wdf_wren = 1'b0;
    app_wdf_end  = 1'b0;
    if (rst) begin
      app_addr = '0;
    end else if (state == ST_WRITE_DATA0) begin
      app_wdf_wren = 1'b1;
      app_wdf_end  = 1'b1;
    end else if (state == ST_WRITE_DATA2) begin
      app_en   = 1'b1;
      app_cmd  = 3'b000;
      app_addr = r_base;
    end else if (state == ST_READ_DATA1) begin
      app_en   = 1'b1;
    end
  end

  assign app_wdf_data   = r_wdf_data;
  assign app_wdf_mask   = r_wdf_mask;
  assign req_strip_cnt  = r_req_cnt;
  assign resp_strip_cnt = r_resp_cnt;
  assign rd_line        = r_rd_line;
  assign rd_data_valid  = app_rd_data_valid && !rst;
  assign rd_line_valid  = r_line_valid && !rst;

endmodule

// File: tb/tb_mpmc10_app_cmd_gen.sv
// Bench for mpmc10_app_cmd_gen: acts as the controller, compares every cycle against a
// strip-level model and pins the model with hand-computed literals.
`timescale 1ns/1ps
module tb_mpmc10_app_cmd_gen;
  localparam int AW = 29;
  localparam int MS = 4;
  localparam logic [3:0] S_IDLE = 4'd0, S_PRESET1 = 4'd1, S_PRESET2 = 4'd2,
                         S_WD0 = 4'd4, S_WD1 = 4'd5, S_WD2 = 4'd6,
                         S_RD0 = 4'd8, S_RD1 = 4'd9, S_RD2 = 4'd10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    state = S_IDLE;
  logic [31:0]   adr_i = '0;
  logic [127:0]  dat_i = '0;
  logic [15:0]   sel_i = '0;
  logic [5:0]    num_strips = '0;
  logic          app_rdy = 1'b0;
  logic          app_wdf_rdy = 1'b0;
  logic [127:0]  app_rd_data = '0;
  logic          app_rd_data_valid = 1'b0;
  logic          app_en, app_wdf_wren, app_wdf_end, rd_data_valid, rd_line_valid;
  logic [2:0]    app_cmd;
  logic [AW-1:0] app_addr;
  logic [127:0]  app_wdf_data;
  logic [15:0]   app_wdf_mask;
  logic [5:0]    req_strip_cnt, resp_strip_cnt;
  logic [128*MS-1:0] rd_line;

  mpmc10_app_cmd_gen #(.ADDR_WIDTH(AW), .MAX_STRIPS(MS)) dut (
    .clk(clk), .rst(rst), .state(state), .adr_i(adr_i), .dat_i(dat_i), .sel_i(sel_i),
    .num_strips(num_strips), .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
    .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .req_strip_cnt(req_strip_cnt), .resp_strip_cnt(resp_strip_cnt),
    .rd_data_valid(rd_data_valid), .rd_line(rd_line), .rd_line_valid(rd_line_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Strip-level model of the datapath
  logic [AW-1:0] m_base;
  logic [127:0]  m_wdata;
  logic [15:0]   m_mask;
  int            m_req, m_resp;
  logic [127:0]  m_line [MS];
  bit            m_done, m_pulse;

  function automatic bit resp_state(input logic [3:0] s);
    return !(s == S_IDLE || s == S_PRESET1 || s == S_PRESET2 || s == 4'd3);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_base <= '0; m_wdata <= '0; m_mask <= '1;
      m_req <= 0; m_resp <= 0; m_done <= 1'b0; m_pulse <= 1'b0;
      for (int i = 0; i < MS; i++) m_line[i] <= '0;
    end else begin
      m_pulse <= 1'b0;
      if (state == S_PRESET2) begin
        m_base <= AW'(adr_i & 32'hFFFF_FFF0);
        m_wdata <= dat_i; m_mask <= ~sel_i;
        m_req <= 0; m_resp <= 0; m_done <= 1'b0;
      end
      if (state == S_RD1 && app_rdy && m_req < int'(num_strips)) m_req <= m_req + 1;
      if (resp_state(state) && app_rd_data_valid && !m_done) begin
        m_line[m_resp % MS] <= app_rd_data;
        if (m_resp < int'(num_strips)) m_resp <= m_resp + 1;
        else begin m_done <= 1'b1; m_pulse <= 1'b1; end
      end
    end
  end

  logic          e_en, e_wr;
  logic [2:0]    e_cmd;
  logic [AW-1:0] e_addr;
  logic [511:0]  e_line;

  always @(negedge clk) begin
    if (chk_en) begin
      e_en = 1'b0; e_wr = 1'b0; e_cmd = 3'b001; e_addr = '0;
      if (!rst) begin
        if (state == S_WD0) e_wr = 1'b1;
        if (state == S_WD2) begin e_en = 1'b1; e_cmd = 3'b000; e_addr = m_base; end
        if (state == S_RD1) begin e_en = 1'b1; e_addr = AW'(32'(m_base) + 32'(16 * m_req)); end
      end
      for (int i = 0; i < MS; i++) e_line[i*128 +: 128] = m_line[i];
      check("app_en", 512'(app_en), 512'(e_en));
      check("app_wdf_wren", 512'(app_wdf_wren), 512'(e_wr));
      check("app_wdf_end", 512'(app_wdf_end), 512'(e_wr));
      if (e_en || rst) begin
        check("app_cmd", 512'(app_cmd), 512'(e_cmd));
        check("app_addr", 512'(app_addr), 512'(e_addr));
      end
      check("app_wdf_data", 512'(app_wdf_data), 512'(m_wdata));
      check("app_wdf_mask", 512'(app_wdf_mask), 512'(m_mask));
      check("req_strip_cnt", 512'(req_strip_cnt), 512'(m_req));
      check("resp_strip_cnt", 512'(resp_strip_cnt), 512'(m_resp));
      check("rd_data_valid", 512'(rd_data_valid), 512'(app_rd_data_valid && !rst));
      check("rd_line", rd_line, e_line);
      check("rd_line_valid", 512'(rd_line_valid), 512'(m_pulse && !rst));
    end
  end

  // Observed handshakes, used by the literal checks
  int n_wren = 0;
  int n_pulse = 0;
  logic [AW+2:0] q_cmd[$];
  always @(negedge clk) begin
    if (chk_en) begin
      if (app_wdf_wren) n_wren++;
      if (rd_line_valid) n_pulse++;
      if (app_en && app_rdy) q_cmd.push_back({app_cmd, app_addr});
    end
  end

  logic [127:0] beats[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_read(input logic [31:0] adr, input logic [5:0] ns);
    state = S_PRESET1; tick();
    state = S_PRESET2; adr_i = adr; num_strips = ns; tick();
    state = S_RD0; q_cmd.delete(); tick();
  endtask

  task automatic issue_cmds(input int n, input bit toggle, input int early);
    int guard = 0;
    int sent = 0;
    state = S_RD1;
    while (q_cmd.size() < n && guard < 40) begin
      app_rdy = toggle ? (guard % 2 == 0) : 1'b1;
      if (guard >= 1 && sent < early && beats.size() > 0) begin
        app_rd_data_valid = 1'b1; app_rd_data = beats.pop_front(); sent++;
      end else begin
        app_rd_data_valid = 1'b0;
      end
      tick();
      guard++;
    end
    app_rdy = 1'b0; app_rd_data_valid = 1'b0; state = S_RD2;
    check("cmd_count", 512'(q_cmd.size()), 512'(n));
  endtask

  task automatic send_beats(input int gap);
    while (beats.size() > 0) begin
      app_rd_data_valid = 1'b1; app_rd_data = beats.pop_front(); tick();
      app_rd_data_valid = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic check_cmds(input string name, input logic [2:0] cmd, input int n,
                            input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                            input logic [AW-1:0] a2, input logic [AW-1:0] a3);
    logic [AW-1:0] addrs[4];
    addrs = '{a0, a1, a2, a3};
    check({name, "_count"}, 512'(q_cmd.size()), 512'(n));
    for (int i = 0; i < n && i < q_cmd.size(); i++)
      check(name, 512'(q_cmd[i]), 512'({cmd, addrs[i]}));
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    check("rst_app_cmd", 512'(app_cmd), 512'(3'b001));
    check("rst_mask", 512'(app_wdf_mask), 512'(16'hFFFF));
    check("rst_app_en", 512'(app_en), 512'(1'b0));
    check("rst_rd_line", rd_line, 512'(0));

    // Write: one beat held until app_wdf_rdy, then the command held until app_rdy
    rst = 1'b0; tick();
    state = S_PRESET1; tick();
    state = S_PRESET2; adr_i = 32'h0000_1234; sel_i = 16'h00FF;
    dat_i = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210; tick();
    state = S_WD0; n_wren = 0; q_cmd.delete();
    for (int i = 0; i < 4; i++) begin
      app_wdf_rdy = (i == 3);
      tick();
    end
    app_wdf_rdy = 1'b0; state = S_WD1;
    @(negedge clk);
    check("wren_cycles", 512'(n_wren), 512'(4));
    check("wr_mask", 512'(app_wdf_mask), 512'(16'hFF00));
    check("wr_data", 512'(app_wdf_data), 512'(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210));
    tick();
    state = S_WD2; app_rdy = 1'b0; tick(); tick();
    app_rdy = 1'b1; tick();
    app_rdy = 1'b0; state = S_IDLE;
    check_cmds("wr_cmd", 3'b000, 1, 29'h1230, 29'h0, 29'h0, 29'h0);
    tick();

    // Read, 4 strips, app_rdy always high, responses back to back
    start_read(32'h0000_1234, 6'd3);
    issue_cmds(4, 1'b0, 0);
    check_cmds("rd_cmd", 3'b001, 4, 29'h1230, 29'h1240, 29'h1250, 29'h1260);
    n_pulse = 0;
    beats.push_back({32{4'hA}}); beats.push_back({32{4'hB}});
    beats.push_back({32{4'hC}}); beats.push_back({32{4'hD}});
    send_beats(0);
    @(negedge clk);
    check("line_pulse_at", 512'(rd_line_valid), 512'(1'b1));
    check("rd_line_abcd", rd_line, {{32{4'hD}}, {32{4'hC}}, {32{4'hB}}, {32{4'hA}}});
    check("req_final", 512'(req_strip_cnt), 512'(3));
    check("resp_final", 512'(resp_strip_cnt), 512'(3));
    tick();
    @(negedge clk);
    check("line_pulse_after", 512'(rd_line_valid), 512'(1'b0));
    check("pulse_count", 512'(n_pulse), 512'(1));
    state = S_IDLE; tick();

    // Read with app_rdy toggling, early beats overlapping commands, one stray beat at the end
    start_read(32'h0000_5678, 6'd3);
    n_pulse = 0;
    beats.push_back({32{4'hE}}); beats.push_back({32{4'hF}});
    beats.push_back({32{4'h1}}); beats.push_back({32{4'h2}});
    issue_cmds(4, 1'b1, 2);
    check_cmds("tog_cmd", 3'b001, 4, 29'h5670, 29'h5680, 29'h5690, 29'h56A0);
    send_beats(1);
    beats.push_back({32{4'h9}});
    send_beats(1);
    @(negedge clk);
    check("tog_line", rd_line, {{32{4'h2}}, {32{4'h1}}, {32{4'hF}}, {32{4'hE}}});
    check("tog_pulses", 512'(n_pulse), 512'(1));
    state = S_IDLE; tick();

    // Address wrap at the top of the MIG address space
    start_read(32'h1FFF_FFF0, 6'd1);
    issue_cmds(2, 1'b0, 0);
    check_cmds("wrap_cmd", 3'b001, 2, 29'h1FFF_FFF0, 29'h0000_0000, 29'h0, 29'h0);
    beats.push_back({32{4'h5}}); beats.push_back({32{4'h6}});
    send_beats(1);
    state = S_IDLE; tick();

    // Reset in the middle of the response phase
    start_read(32'h0000_2000, 6'd3);
    issue_cmds(4, 1'b0, 0);
    n_pulse = 0;
    beats.push_back({32{4'h7}}); beats.push_back({32{4'h8}});
    send_beats(0);
    rst = 1'b1; state = S_IDLE; tick();
    @(negedge clk);
    check("mid_rst_req", 512'(req_strip_cnt), 512'(0));
    check("mid_rst_resp", 512'(resp_strip_cnt), 512'(0));
    check("mid_rst_line", rd_line, 512'(0));
    check("mid_rst_en", 512'(app_en), 512'(1'b0));
    rst = 1'b0; tick();
    beats.push_back({32{4'h3}});
    send_beats(2);
    @(negedge clk);
    check("stray_line", rd_line, 512'(0));
    check("stray_resp", 512'(resp_strip_cnt), 512'(0));
    check("rst_pulses", 512'(n_pulse), 512'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mpmc10_app_cmd_gen.md
Name: mpmc10_app_cmd_gen

Overview:
- Datapath/command stage directly downstream of the mpmc10 write-back controller state machine.
- Decodes the controller state into MIG user-interface (app_*) command and write-data strobes.
- Generates per-strip read addresses, counts requested/returned 128-bit strips (feeding req_strip_cnt/resp_strip_cnt/rd_data_valid back to the controller) and assembles returned strips into a cache line.

Parameters:
- ADDR_WIDTH, 29, MIG app_addr width (byte address).
- MAX_STRIPS, 4, strips per line buffer; rd_line width = 128*MAX_STRIPS.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- state  in  4  controller state (mpmc10_pkg encoding)
- adr_i  in  32  request byte address (fifo_out)
- dat_i  in  128  write data (fifo_out)
- sel_i  in  16  byte selects (fifo_out)
- num_strips  in  6  strips to read minus one
- app_rdy  in  1  MIG command ready
- app_wdf_rdy  in  1  MIG write-data ready
- app_en  out  1  command valid
- app_cmd  out  3  000=write, 001=read
- app_addr  out  ADDR_WIDTH  command address
- app_wdf_wren  out  1  write-data valid
- app_wdf_end  out  1  last write beat
- app_wdf_data  out  128  write data
- app_wdf_mask  out  16  byte mask, 1=masked
- app_rd_data  in  128  read data
- app_rd_data_valid  in  1  read data valid
- req_strip_cnt  out  6  read commands accepted
- resp_strip_cnt  out  6  read beats received
- rd_data_valid  out  1  to controller
- rd_line  out  128*MAX_STRIPS  assembled read line
- rd_line_valid  out  1  one-cycle line-complete pulse

Behaviour:
- Reset: app_en, app_wdf_wren, app_wdf_end, rd_line_valid = 0; app_cmd = 001; app_addr, app_wdf_data, rd_line = 0; app_wdf_mask = all-ones; req/resp counters = 0. All strobes forced 0 while rst is high, regardless of state.
- PRESET2 (one cycle), registered:
  - base <= {adr_i[ADDR_WIDTH-1:4], 4'h0}
  - app_wdf_data <= dat_i
  - app_wdf_mask <= ~sel_i
  - req_strip_cnt <= 0, resp_strip_cnt <= 0
- Combinational strobes decoded from state:
  - WRITE_DATA0: app_wdf_wren = app_wdf_end = 1. Beat is accepted in the cycle app_wdf_rdy=1; the controller leaves the next cycle, so exactly one beat is issued.
  - WRITE_DATA2: app_en = 1, app_cmd = 000, app_addr = base; held until app_rdy.
  - READ_DATA1: app_en = 1, app_cmd = 001, app_addr = base + {req_strip_cnt, 4'h0}, truncated to ADDR_WIDTH (wraps).
  - All other states: app_en = app_wdf_wren = app_wdf_end = 0.
- Read request count: in READ_DATA1, app_rdy=1 and req_strip_cnt < num_strips -> req_strip_cnt += 1. At req_strip_cnt == num_strips with app_rdy, the last command is accepted and the count holds, since the controller exits. Total commands = num_strips+1.
- Read responses (any state except IDLE/PRESETx; covers early returns during READ_DATA1):
  - On app_rd_data_valid: rd_line[resp_strip_cnt*128 +: 128] <= app_rd_data.
  - If resp_strip_cnt < num_strips: resp_strip_cnt += 1.
  - Else: rd_line_valid = 1 next cycle (single pulse).
  - Beats arriving after the last strip, or in IDLE, are dropped and never write rd_line.
- rd_data_valid = app_rd_data_valid (combinational), so the controller samples the last beat with resp_strip_cnt == num_strips.
- num_strips >= MAX_STRIPS is out of contract; strip index is taken mod MAX_STRIPS.
- Reset mid-read: counters cleared; rd_line retains nothing (cleared); no rd_line_valid pulse.
- Simultaneous app_rdy and app_rd_data_valid in READ_DATA1: both counters update in the same cycle, independently.

Test Plan:
- Write: adr_i=0x0000_1234, sel_i=0x00FF, app_wdf_rdy low 3 cycles then high -> app_wdf_wren high 4 cycles; app_wdf_mask=0xFF00; app_en/app_cmd=000 with app_addr=0x1230 until app_rdy.
- Read, num_strips=3, app_rdy always 1 -> 4 commands at 0x1230/0x1240/0x1250/0x1260; req_strip_cnt ends at 3.
- Read with app_rdy toggling 1010... -> no duplicate or skipped addresses; 4 distinct commands.
- Responses 0xA..,0xB..,0xC..,0xD.. -> rd_line = {D,C,B,A}; one rd_line_valid pulse one cycle after beat 4; resp_strip_cnt=3.
- Base 0x1FFF_FFF0, num_strips=1 -> second address wraps to 0x0000_0000.
- rst asserted after 2 response beats -> all counters and strobes 0 next cycle; no rd_line_valid; a stray later beat is ignored.
